// File: rtl/addsub_pkg.sv
// Shared types and reference arithmetic for the adder/subtractor self-test engine.
package addsub_pkg;

  localparam int ADDSUB_W = 4;
  localparam int VEC_W    = 2*ADDSUB_W + 1;
  localparam int NUM_VEC  = 2**VEC_W;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    CHECK,
    DONE
  } state_t;

  // Subtract is a + ~b + 1, so carry-out doubles as "no borrow" in subtract mode.
  function automatic logic [ADDSUB_W:0] golden_addsub(input logic [ADDSUB_W-1:0] a,
                                                      input logic [ADDSUB_W-1:0] b,
                                                      input logic                m);
    return {1'b0, a} + {1'b0, b ^ {ADDSUB_W{m}}} + {{ADDSUB_W{1'b0}}, m};
  endfunction

endpackage

// File: rtl/addsub_golden.sv
// Behavioural reference model of the adder/subtractor, independent of any ripple structure.
module addsub_golden
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic [WIDTH:0]   res
);

  generate
    if (WIDTH == ADDSUB_W) begin : g_pkg
      assign res = golden_addsub(a, b, m);
    end else begin : g_generic
      assign res = {1'b0, a} + {1'b0, b ^ {WIDTH{m}}} + {{WIDTH{1'b0}}, m};
    end
  endgenerate

endmodule

// File: rtl/addsub4_bist.sv
// Exhaustive self-test engine: sweeps every (a, b, mode) vector into the adder/subtractor
// and checks its result against the behavioural reference.
module addsub4_bist
  import addsub_pkg::*;
#(
  parameter int WIDTH         = ADDSUB_W,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dut_s,
  input  logic                 dut_cout,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  output logic                 op_m,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH:0]     first_fail
);

  localparam int VW = 2*WIDTH + 1;

  state_t         state, state_nxt;
  logic [VW-1:0]  idx;
  logic [3:0]     settle_cnt;
  logic [WIDTH:0] gold;
  logic           mismatch;
  logic           last_vec;
  logic           settle_end;

  // Operands are pure slices of the registered vector index, so they only move with idx.
  assign op_b = idx[WIDTH-1:0];
  assign op_a = idx[2*WIDTH-1:WIDTH];
  assign op_m = idx[2*WIDTH];

  addsub_golden #(.WIDTH(WIDTH)) u_golden (
    .a   (op_a),
    .b   (op_b),
    .m   (op_m),
    .res (gold)
  );

  assign mismatch   = ({dut_cout, dut_s} != gold);
  assign last_vec   = &idx;
  assign settle_end = (settle_cnt == 4'(SETTLE_CYCLES - 1));

  assign busy = (state == APPLY) || (state == WAIT) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = APPLY;
      APPLY:      state_nxt = WAIT;
      WAIT:       if (settle_end) state_nxt = CHECK;
      CHECK:      state_nxt = last_vec ? DONE : APPLY;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            idx        <= '0;
            err_count  <= '0;
            first_fail <= '0;
          end
        end
        APPLY: settle_cnt <= '0;
        WAIT:  if (!settle_end) settle_cnt <= settle_cnt + 4'd1;
        CHECK: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (err_count == '0) first_fail <= idx;
          end
          if (!last_vec) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub4_bist.sv
// Bench for addsub4_bist: a behavioural adder/subtractor with selectable faults stands in
// for the device under test; sweep results are checked through an expectation queue.
module tb_addsub4_bist;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start3 = 1'b0;
  int         fault = 0;

  logic [3:0] dut_s, op_a, op_b;
  logic       dut_cout, op_m, busy, done, pass;
  logic [9:0] err_count;
  logic [8:0] first_fail;

  logic [3:0] dut_s3, op_a3, op_b3;
  logic       dut_cout3, op_m3, busy3, done3, pass3;
  logic [9:0] err_count3;
  logic [8:0] first_fail3;

  logic [4:0] model_r, model_r3;

  initial forever #5 clk = ~clk;

  // Stand-in adder/subtractor; fault 1 = S[0] stuck at 0, fault 2 = Cout stuck at 0.
  assign model_r   = {1'b0, op_a} + {1'b0, op_b ^ {4{op_m}}} + {4'd0, op_m};
  assign dut_s     = (fault == 1) ? {model_r[3:1], 1'b0} : model_r[3:0];
  assign dut_cout  = (fault == 2) ? 1'b0 : model_r[4];
  assign model_r3  = {1'b0, op_a3} + {1'b0, op_b3 ^ {4{op_m3}}} + {4'd0, op_m3};
  assign dut_s3    = model_r3[3:0];
  assign dut_cout3 = model_r3[4];

  addsub4_bist u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_s(dut_s), .dut_cout(dut_cout),
    .op_a(op_a), .op_b(op_b), .op_m(op_m), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail)
  );

  addsub4_bist #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .dut_s(dut_s3), .dut_cout(dut_cout3),
    .op_a(op_a3), .op_b(op_b3), .op_m(op_m3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err_count3), .first_fail(first_fail3)
  );

  typedef struct {
    logic pass_e;
    int   err_e;
    int   ff_e;
    int   lat_e;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   start_edge = 0;
  int   hold_bad3 = 0;
  int   n_chg3 = 0;
  int   last_chg3 = 0;
  logic [8:0] last_ops3 = '0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every rising edge of done retires one expected sweep result.
  initial forever begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no completion", cyc);
      end else begin
        e = exp_q.pop_front();
        check("pass", int'(pass), int'(e.pass_e));
        check("err_count", int'(err_count), e.err_e);
        if (!e.pass_e) check("first_fail", int'(first_fail), e.ff_e);
        check("done_latency", cyc - start_edge, e.lat_e);
        check("busy_at_done", int'(busy), 0);
        check("end_op_m", int'(op_m), 1);
        check("end_op_a", int'(op_a), 15);
        check("end_op_b", int'(op_b), 15);
      end
    end
    done_prev = done;
  end

  // Operand hold time on the slow-settle instance: each vector must persist 5 cycles.
  initial forever begin
    @(posedge clk);
    #1;
    if ({op_m3, op_a3, op_b3} != last_ops3) begin
      if (last_chg3 != 0 && (cyc - last_chg3) != 5) hold_bad3++;
      last_chg3 = cyc;
      last_ops3 = {op_m3, op_a3, op_b3};
      n_chg3++;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start_edge = cyc;
    start = 1'b0;
  endtask

  task automatic wait_sweep(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sweep_timeout: no done within %0d cycles, expected completion", budget);
      exp_q.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int s3;
    int k;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_first_fail", int'(first_fail), 0);
    check("rst_ops", int'({op_m, op_a, op_b}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_without_start", int'(busy), 0);

    // Correct DUT at defaults; also confirm 3 cycles per vector.
    exp_q.push_back('{1'b1, 0, 0, 1536});
    pulse_start();
    check("start_busy", int'(busy), 1);
    check("start_ops", int'({op_m, op_a, op_b}), 0);
    repeat (2) @(posedge clk);
    #1;
    check("vec0_hold_b", int'(op_b), 0);
    @(posedge clk);
    #1;
    check("vec1_b", int'(op_b), 1);
    wait_sweep(2000);

    // S[0] stuck at 0, restarted directly from DONE.
    fault = 1;
    exp_q.push_back('{1'b0, 256, 1, 1536});
    pulse_start();
    wait_sweep(2000);

    // Restart from DONE clears results; a start at cycle 100 must be ignored.
    fault = 0;
    exp_q.push_back('{1'b1, 0, 0, 1536});
    pulse_start();
    check("restart_done_clear", int'(done), 0);
    check("restart_err_clear", int'(err_count), 0);
    check("restart_busy", int'(busy), 1);
    repeat (99) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignored_start_busy", int'(busy), 1);
    wait_sweep(2000);

    // Cout stuck at 0.
    fault = 2;
    exp_q.push_back('{1'b0, 256, 31, 1536});
    pulse_start();
    wait_sweep(2000);

    // Asynchronous reset mid-sweep, mid-cycle.
    fault = 1;
    pulse_start();
    repeat (699) @(posedge clk);
    #3;
    check("pre_reset_err_nonzero", int'(err_count != 0), 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_ops", int'({op_m, op_a, op_b}), 0);
    check("async_rst_err", int'(err_count), 0);
    check("async_rst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_idle_busy", int'(busy), 0);
    check("post_rst_idle_done", int'(done), 0);
    check("post_rst_idle_ops", int'({op_m, op_a, op_b}), 0);

    // SETTLE_CYCLES = 3 instance.
    fault = 0;
    n_chg3 = 0;
    hold_bad3 = 0;
    last_chg3 = 0;
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    s3 = cyc;
    start3 = 1'b0;
    k = 0;
    while (done3 !== 1'b1 && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (done3 !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL settle3_timeout: no done within 3000 cycles, expected completion");
    end else begin
      check("settle3_latency", cyc - s3, 2560);
      check("settle3_pass", int'(pass3), 1);
      check("settle3_err", int'(err_count3), 0);
      check("settle3_first_fail", int'(first_fail3), 0);
      check("settle3_busy", int'(busy3), 0);
      check("settle3_vector_changes", n_chg3, 511);
      check("settle3_hold_violations", hold_bad3, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
